// File: rtl/lock_code_sender.sv
// ---------------------------------------------------------------------------
// lock_code_sender
//
// Initiator for the digital_lock entry interface. On a start request it plays
// the stored unlock code onto the lock's symbol bus, one symbol per clock,
// then watches the lock's y output for confirmation. If y does not rise
// within TIMEOUT cycles it drives idle symbols for GAP_CYCLES cycles (so the
// lock falls back to its reset state) and retries, up to MAX_RETRY times.
//
// Handshake: the request side has no ready wire. start/load_en are accepted
// only on a clock edge where busy is low (FSM in IDLE); any start or load_en
// seen while busy is high is dropped, not queued. done pulses for exactly one
// cycle when a sequence ends, with unlocked/failed already valid in that
// cycle and held until the next accepted start or reset.
//
// Optional feature macro: LOCK_CODE_SENDER_ABORT_EN adds an abort input that
// ends an active sequence as failed (y_in success in CHECK takes priority).
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   start      request a send (sampled in IDLE only)
//   load_en    write code register from load_code (IDLE only)
//   load_code  new code, symbol 0 in the LSBs
//   y_in       unlock indication from the lock
//   abort      (macro only) abandon the active sequence
//   x          registered symbol to the lock
//   busy       high in every state except IDLE
//   done       one-cycle pulse at sequence end
//   unlocked   sticky success flag
//   failed     sticky failure flag
//   attempts   attempts made in the current or last sequence
//   dbg_state  current FSM state encoding, for checkers
// ---------------------------------------------------------------------------
module lock_code_sender #(
   parameter int                      SYM_W        = 3,
   parameter int                      CODE_LEN     = 3,
   parameter logic [CODE_LEN*SYM_W-1:0] DEFAULT_CODE = 9'b101_111_011,
   parameter logic [SYM_W-1:0]        IDLE_SYM     = 3'b000,
   parameter int                      TIMEOUT      = 4,
   parameter int                      GAP_CYCLES   = 2,
   parameter int                      MAX_RETRY    = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      load_en,
   input  logic [CODE_LEN*SYM_W-1:0] load_code,
   input  logic                      y_in,
`ifdef LOCK_CODE_SENDER_ABORT_EN
   input  logic                      abort,
`endif
   output logic [SYM_W-1:0]          x,
   output logic                      busy,
   output logic                      done,
   output logic                      unlocked,
   output logic                      failed,
   output logic [1:0]                attempts,
   output logic [2:0]                dbg_state
);

   localparam int CODE_W  = CODE_LEN * SYM_W;
   localparam int IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
   localparam int TIMER_W = $clog2(TIMEOUT + 1);
   localparam int GAP_W   = $clog2(GAP_CYCLES + 1);

   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(CODE_LEN - 1);
   localparam logic [TIMER_W-1:0] TIMER_END = TIMER_W'(TIMEOUT);
   localparam logic [GAP_W-1:0]   GAP_END   = GAP_W'(GAP_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SEND  = 3'd1,
      S_CHECK = 3'd2,
      S_GAP   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [CODE_W-1:0]    code_q, code_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic [1:0]           attempts_q, attempts_d;
   logic [SYM_W-1:0]     x_q, x_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 unlocked_q, unlocked_d;
   logic                 failed_q, failed_d;

   logic                 abort_req;
   logic [SYM_W-1:0]     sym_d [CODE_LEN];

`ifdef LOCK_CODE_SENDER_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // Split the next-cycle code into symbols so x can be driven from the
   // freshly loaded code when load_en and start arrive together.
   always_comb begin
      for (int i = 0; i < CODE_LEN; i++) begin
         sym_d[i] = code_d[i*SYM_W +: SYM_W];
      end
   end

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      idx_d      = idx_q;
      timer_d    = timer_q;
      gap_d      = gap_q;
      attempts_d = attempts_q;
      unlocked_d = unlocked_q;
      failed_d   = failed_q;

      case (state_q)
         S_IDLE: begin
            if (load_en) begin
               code_d = load_code;
            end
            if (start) begin
               unlocked_d = 1'b0;
               failed_d   = 1'b0;
               attempts_d = 2'd1;
               idx_d      = '0;
               state_d    = S_SEND;
            end
         end

         S_SEND: begin
            if (abort_req) begin
               failed_d = 1'b1;
               state_d  = S_DONE;
            end else if (idx_q == LAST_IDX) begin
               timer_d = TIMER_W'(1);
               state_d = S_CHECK;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         S_CHECK: begin
            // Success has priority over abort and timeout in the same cycle.
            if (y_in) begin
               unlocked_d = 1'b1;
               state_d    = S_DONE;
            end else if (abort_req) begin
               failed_d = 1'b1;
               state_d  = S_DONE;
            end else if (timer_q == TIMER_END) begin
               if (32'(attempts_q) <= MAX_RETRY) begin
                  gap_d   = GAP_W'(1);
                  state_d = S_GAP;
               end else begin
                  failed_d = 1'b1;
                  state_d  = S_DONE;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         S_GAP: begin
            if (abort_req) begin
               failed_d = 1'b1;
               state_d  = S_DONE;
            end else if (gap_q == GAP_END) begin
               attempts_d = attempts_q + 2'd1;
               idx_d      = '0;
               state_d    = S_SEND;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Registered outputs are derived from the next state so that each output
   // lines up with the cycle in which the FSM occupies that state.
   always_comb begin
      x_d = IDLE_SYM;
      if (state_d == S_SEND) begin
         x_d = sym_d[idx_d];
      end
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         code_q     <= DEFAULT_CODE;
         idx_q      <= '0;
         timer_q    <= '0;
         gap_q      <= '0;
         attempts_q <= 2'd0;
         x_q        <= IDLE_SYM;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         unlocked_q <= 1'b0;
         failed_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         idx_q      <= idx_d;
         timer_q    <= timer_d;
         gap_q      <= gap_d;
         attempts_q <= attempts_d;
         x_q        <= x_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         unlocked_q <= unlocked_d;
         failed_q   <= failed_d;
      end
   end

   assign x         = x_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign unlocked  = unlocked_q;
   assign failed    = failed_q;
   assign attempts  = attempts_q;
   assign dbg_state = state_q;

endmodule
